dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_responder_if.sv | 11 +
 rtl/dmem_mmio.sv | 100 ++++++++++
 rtl/dmem_responder.sv | 77 +++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder.
// MMIO map constants are used only when DMEM_MMIO_EN is defined.
package dmem_pkg;

    localparam int          DEPTH_WORDS_DEF = 1024;

    localparam logic [15:0] MMIO_BASE = 16'hBFAF;
    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_SW    = 16'hF004;
    localparam logic [15:0] OFF_TIMER = 16'hF008;
    localparam logic [15:0] OFF_CMP   = 16'hF00C;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    // Replace the byte lanes of old_w selected by wen with those of new_w.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Word offset of a byte offset inside the MMIO page.
    function automatic logic [13:0] word_off(input logic [15:0] off);
        return off[15:2];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory bus: byte address, lane write enables, lane-aligned write data
// and registered read data.
interface dmem_responder_if;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (output dm_addr, output dm_wen, output dm_wdata, input dm_rdata);
    modport slave  (input dm_addr, input dm_wen, input dm_wdata, output dm_rdata);
endinterface

// File: rtl/dmem_mmio.sv
// Memory-mapped peripherals: LED register, switch synchronizer, free-running
// timer with compare and sticky compare flag. Built only with DMEM_MMIO_EN.
module dmem_mmio
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [15:0] offset,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    input  logic [15:0] sw_in,
    output logic [31:0] rd_data,
    output logic [15:0] led_out,
    output logic        timer_irq
);

    logic [15:0] led_reg;
    logic [15:0] sync1_reg, sync2_reg;
    logic [31:0] timer_reg, timer_next;
    logic [31:0] cmp_reg;
    logic        irq_reg;
    logic        wr_any;
    logic        hit_led, hit_sw, hit_timer, hit_cmp;
    logic        unused_offset;

    assign unused_offset = ^offset[1:0];

    assign wr_any    = sel && (wen != 4'b0000);
    assign hit_led   = (offset[15:2] == word_off(OFF_LED));
    assign hit_sw    = (offset[15:2] == word_off(OFF_SW));
    assign hit_timer = (offset[15:2] == word_off(OFF_TIMER));
    assign hit_cmp   = (offset[15:2] == word_off(OFF_CMP));

    // LED register: only the low two lanes exist.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_reg <= '0;
        end else if (wr_any && hit_led) begin
            if (wen[0]) led_reg[7:0]  <= wdata[7:0];
            if (wen[1]) led_reg[15:8] <= wdata[15:8];
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Timer load replaces the increment in the cycle it is written.
    always_comb begin
        timer_next = timer_reg + 32'd1;
        if (wr_any && hit_timer) begin
            timer_next = merge_lanes(timer_reg, wdata, wen);
        end
    end

    // Timer and compare registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_reg <= '0;
            cmp_reg   <= CMP_RESET;
        end else begin
            timer_reg <= timer_next;
            if (wr_any && hit_cmp) begin
                cmp_reg <= merge_lanes(cmp_reg, wdata, wen);
            end
        end
    end

    // Sticky compare flag; a compare-register write clears it and wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_reg <= 1'b0;
        end else if (wr_any && hit_cmp) begin
            irq_reg <= 1'b0;
        end else if (timer_reg == cmp_reg) begin
            irq_reg <= 1'b1;
        end
    end

    // Read mux reflects register contents before any same-cycle write.
    always_comb begin
        rd_data = '0;
        if (hit_led)   rd_data = {16'h0000, led_reg};
        if (hit_sw)    rd_data = {16'h0000, sync2_reg};
        if (hit_timer) rd_data = timer_reg;
        if (hit_cmp)   rd_data = cmp_reg;
    end

    assign led_out   = led_reg;
    assign timer_irq = irq_reg;

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with byte-lane writes, one-cycle registered
// write-first reads, and an optional MMIO page enabled by DMEM_MMIO_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              resetn,
    dmem_responder_if.slave   dm,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              timer_irq
);

    logic [31:0]      ram [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             is_mmio;
    logic [31:0]      mmio_rd;
    logic [31:0]      rdata_reg;
    logic             unused_addr;

    // Upper address bits alias onto the RAM; byte offset is the initiator's job.
    assign unused_addr = ^{dm.dm_addr[31:IDX_W+2], dm.dm_addr[1:0]};
    assign idx         = dm.dm_addr[IDX_W+1:2];

`ifdef DMEM_MMIO_EN
    assign is_mmio = (dm.dm_addr[31:16] == MMIO_BASE);

    dmem_mmio u_mmio (
        .clk       (clk),
        .resetn    (resetn),
        .sel       (is_mmio),
        .offset    (dm.dm_addr[15:0]),
        .wen       (dm.dm_wen),
        .wdata     (dm.dm_wdata),
        .sw_in     (sw_in),
        .rd_data   (mmio_rd),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );
`else
    logic unused_sw;

    assign is_mmio   = 1'b0;
    assign mmio_rd   = '0;
    assign led_out   = '0;
    assign timer_irq = 1'b0;
    assign unused_sw = ^sw_in;
`endif

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (dm.dm_wen[i]) begin
                    ram[idx][8*i +: 8] <= dm.dm_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read every cycle; written lanes bypass to give write-first data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_reg <= '0;
        end else if (is_mmio) begin
            rdata_reg <= mmio_rd;
        end else begin
            rdata_reg <= merge_lanes(ram[idx], dm.dm_wdata, dm.dm_wen);
        end
    end

    assign dm.dm_rdata = rdata_reg;

endmodule
